// File: rtl/apb_reg_slave.sv
// rtl/apb_reg_slave.sv - APB completer with NUM_REGS 32-bit registers, read-only ID at index 0,
// configurable wait states and registered ready/error/read-data outputs.
module apb_reg_slave #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] pwdata,
  input  logic        pclken,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [IW-1:0] idx_q;
  logic          wr_q, err_q;
  logic [31:0]   regs [NUM_REGS];

  logic          setup, complete;
  logic [IW-1:0] live_idx, cur_idx;
  logic          live_err, cur_err, cur_wr;
  logic [31:0]   prdata_nxt;
  logic          pready_nxt, pslverr_nxt;

  assign setup    = psel && !penable;
  assign complete = (state == S_READY) && psel && penable;
  assign live_idx = paddr[IW+1:2];
  assign live_err = (paddr[1:0] != 2'b00) ||
                    (paddr[31:2] >= 30'(NUM_REGS)) ||
                    (pwrite && (paddr[31:2] == 30'd0));

  // In IDLE the response is built from the live bus so zero-wait transfers work.
  assign cur_idx = (state == S_IDLE) ? live_idx : idx_q;
  assign cur_err = (state == S_IDLE) ? live_err : err_q;
  assign cur_wr  = (state == S_IDLE) ? pwrite   : wr_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= S_IDLE;
    end else if (pclken) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (setup) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_READY;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt <= 4'd1) begin
          state_nxt = S_READY;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_READY: begin
        if (!psel || penable) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    pready_nxt  = 1'b0;
    pslverr_nxt = 1'b0;
    prdata_nxt  = 32'd0;
    if (state_nxt == S_READY) begin
      pready_nxt  = 1'b1;
      pslverr_nxt = cur_err;
      if (state == S_READY) begin
        prdata_nxt = prdata;
      end else if (!cur_err && !cur_wr) begin
        prdata_nxt = (cur_idx == '0) ? ID_VALUE : regs[cur_idx];
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt     <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      prdata  <= 32'd0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else if (pclken) begin
      cnt     <= cnt_nxt;
      prdata  <= prdata_nxt;
      pready  <= pready_nxt;
      pslverr <= pslverr_nxt;
      if (state == S_IDLE && setup) begin
        idx_q <= live_idx;
        wr_q  <= pwrite;
        err_q <= live_err;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 32'd0;
    end else if (pclken && complete && wr_q && !err_q) begin
      regs[idx_q] <= pwdata;
    end
  end

endmodule
